// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the RV32 pipeline controller.
//   - ctrl_state_e    : controller FSM encoding (RUN, MEM_WAIT, HALT)
//   - TRAP_VECTOR_DEF : default trap redirect address
//   - REG_ZERO        : architectural x0, never a forwarding/hazard source
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0004;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// fwd_unit: execute-stage operand forwarding selects (pure combinational).
// Ports:
//   ex_rs1_i, ex_rs2_i      : source registers of the instruction in ID/EX
//   mem_rd_i, mem_write_reg_i : destination / write enable in EX/MEM
//   wb_rd_i,  wb_write_reg_i  : destination / write enable in MEM/WB
//   use_*_o                 : one-hot-or-zero select per operand; the younger
//                             EX/MEM result wins over MEM/WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_write_reg_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_write_reg_i,
  output logic       use_EX_MEM_rs1_o,
  output logic       use_EX_MEM_rs2_o,
  output logic       use_MEM_WB_rs1_o,
  output logic       use_MEM_WB_rs2_o
);

  logic mem_valid;
  logic wb_valid;

  // x0 is hardwired, so a writer targeting it never produces a usable value.
  assign mem_valid = mem_write_reg_i && (mem_rd_i != REG_ZERO);
  assign wb_valid  = wb_write_reg_i  && (wb_rd_i  != REG_ZERO);

  assign use_EX_MEM_rs1_o = mem_valid && (mem_rd_i == ex_rs1_i);
  assign use_EX_MEM_rs2_o = mem_valid && (mem_rd_i == ex_rs2_i);
  assign use_MEM_WB_rs1_o = wb_valid  && (wb_rd_i  == ex_rs1_i) && !use_EX_MEM_rs1_o;
  assign use_MEM_WB_rs2_o = wb_valid  && (wb_rd_i  == ex_rs2_i) && !use_EX_MEM_rs2_o;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard/flush/stall controller for the 5-stage core.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   id_*_i                       : operands read by the instruction in ID
//   ex_*_i, mem_*_i, wb_*_i      : pipeline register fields for forwarding/hazards
//   ex_load_target_i             : taken branch/jump in EX
//   mem_busy_i                   : data memory wait state
//   wb_trap_i                    : trapping instruction in MEM/WB
//   use_*_o                      : forwarding selects
//   freeze_o, stall_fetch_o      : global hold / fetch hold
//   flush_*_o                    : stage register clear to bubble
//   pc_load_o, pc_trap_o         : PC redirect to branch target / TRAP_VECTOR
//   halted_o                     : core stopped after a halting trap
//   stall_cnt_o, flush_cnt_o     : saturating event counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; forwarding, load-use, branch and trap handling
// MEM_WAIT | data memory busy seen; pipeline frozen until it drops
// HALT     | halting trap retired; fetch stalled, EX bubbled until reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          TRAP_HALT   = 1'b1,
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_write_reg_i,
  input  logic             ex_read_mem_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_write_reg_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_write_reg_i,
  input  logic             ex_load_target_i,
  input  logic             mem_busy_i,
  input  logic             wb_trap_i,
  output logic             use_EX_MEM_rs1_o,
  output logic             use_EX_MEM_rs2_o,
  output logic             use_MEM_WB_rs1_o,
  output logic             use_MEM_WB_rs2_o,
  output logic             freeze_o,
  output logic             stall_fetch_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_ex_mem_o,
  output logic             pc_load_o,
  output logic             pc_trap_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // The PC mux consumes TRAP_VECTOR directly; it must be word aligned.
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_vector
    $error("TRAP_VECTOR must be word aligned");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             stall_evt, flush_evt;

  fwd_unit u_fwd (
    .ex_rs1_i         (ex_rs1_i),
    .ex_rs2_i         (ex_rs2_i),
    .mem_rd_i         (mem_rd_i),
    .mem_write_reg_i  (mem_write_reg_i),
    .wb_rd_i          (wb_rd_i),
    .wb_write_reg_i   (wb_write_reg_i),
    .use_EX_MEM_rs1_o (use_EX_MEM_rs1_o),
    .use_EX_MEM_rs2_o (use_EX_MEM_rs2_o),
    .use_MEM_WB_rs1_o (use_MEM_WB_rs1_o),
    .use_MEM_WB_rs2_o (use_MEM_WB_rs2_o)
  );

  assign load_use = ex_read_mem_i && ex_write_reg_i && (ex_rd_i != REG_ZERO) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  // Priority in RUN/MEM_WAIT: trap > memory freeze > branch > load-use.
  // MEM_WAIT behaves like RUN once busy drops, so a branch held in EX
  // during the wait is taken on the first unfrozen cycle.
  always_comb begin
    state_d        = state_q;
    freeze_o       = 1'b0;
    stall_fetch_o  = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    flush_ex_mem_o = 1'b0;
    pc_load_o      = 1'b0;
    pc_trap_o      = 1'b0;
    stall_evt      = 1'b0;
    flush_evt      = 1'b0;
    case (state_q)
      ST_HALT: begin
        stall_fetch_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
      default: begin
        if (wb_trap_i) begin
          flush_if_id_o  = 1'b1;
          flush_id_ex_o  = 1'b1;
          flush_ex_mem_o = 1'b1;
          pc_trap_o      = ~TRAP_HALT;
          flush_evt      = 1'b1;
          state_d        = TRAP_HALT ? ST_HALT : ST_RUN;
        end else if (mem_busy_i) begin
          freeze_o  = 1'b1;
          stall_evt = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if (ex_load_target_i) begin
            pc_load_o     = 1'b1;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            flush_evt     = 1'b1;
          end else if (load_use) begin
            stall_fetch_o = 1'b1;
            flush_id_ex_o = 1'b1;
            stall_evt     = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      halted_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_o <= (state_d == ST_HALT);
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk, reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_write, ex_read_mem, mem_wr, wb_wr;
  logic branch, busy, trap_h, trap_r;

  // h: halting trap, 16-bit counters.  r: redirecting trap, 3-bit counters.
  logic fe1_h, fe2_h, fw1_h, fw2_h, frz_h, stl_h, fif_h, fid_h, fex_h, pcl_h, pct_h, hlt_h;
  logic fe1_r, fe2_r, fw1_r, fw2_r, frz_r, stl_r, fif_r, fid_r, fex_r, pcl_r, pct_r, hlt_r;
  logic [15:0] scnt_h, fcnt_h;
  logic [2:0]  scnt_r, fcnt_r;

  logic [11:0] obs_h, obs_r;
  assign obs_h = {fe1_h, fe2_h, fw1_h, fw2_h, frz_h, stl_h, fif_h, fid_h, fex_h, pcl_h, pct_h, hlt_h};
  assign obs_r = {fe1_r, fe2_r, fw1_r, fw2_r, frz_r, stl_r, fif_r, fid_r, fex_r, pcl_r, pct_r, hlt_r};

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.TRAP_HALT(1'b1), .CNT_W(16)) dut_h (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
    .ex_write_reg_i(ex_write), .ex_read_mem_i(ex_read_mem),
    .mem_rd_i(mem_rd), .mem_write_reg_i(mem_wr), .wb_rd_i(wb_rd), .wb_write_reg_i(wb_wr),
    .ex_load_target_i(branch), .mem_busy_i(busy), .wb_trap_i(trap_h),
    .use_EX_MEM_rs1_o(fe1_h), .use_EX_MEM_rs2_o(fe2_h),
    .use_MEM_WB_rs1_o(fw1_h), .use_MEM_WB_rs2_o(fw2_h),
    .freeze_o(frz_h), .stall_fetch_o(stl_h), .flush_if_id_o(fif_h),
    .flush_id_ex_o(fid_h), .flush_ex_mem_o(fex_h), .pc_load_o(pcl_h),
    .pc_trap_o(pct_h), .halted_o(hlt_h), .stall_cnt_o(scnt_h), .flush_cnt_o(fcnt_h)
  );

  pipe_hazard_ctrl #(.TRAP_HALT(1'b0), .CNT_W(3)) dut_r (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
    .ex_write_reg_i(ex_write), .ex_read_mem_i(ex_read_mem),
    .mem_rd_i(mem_rd), .mem_write_reg_i(mem_wr), .wb_rd_i(wb_rd), .wb_write_reg_i(wb_wr),
    .ex_load_target_i(branch), .mem_busy_i(busy), .wb_trap_i(trap_r),
    .use_EX_MEM_rs1_o(fe1_r), .use_EX_MEM_rs2_o(fe2_r),
    .use_MEM_WB_rs1_o(fw1_r), .use_MEM_WB_rs2_o(fw2_r),
    .freeze_o(frz_r), .stall_fetch_o(stl_r), .flush_if_id_o(fif_r),
    .flush_id_ex_o(fid_r), .flush_ex_mem_o(fex_r), .pc_load_o(pcl_r),
    .pc_trap_o(pct_r), .halted_o(hlt_r), .stall_cnt_o(scnt_r), .flush_cnt_o(fcnt_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_halt_h, m_halt_r;
  int m_stall_h, m_flush_h, m_stall_r, m_flush_r;

  // Forwarding: for each EX operand, take the youngest in-flight producer
  // (EX/MEM before MEM/WB) that writes that nonzero register.
  function automatic logic [3:0] ref_fwd();
    logic [4:0] src [2];
    logic [4:0] prd [2];
    logic       pwr [2];
    int         pick [2];
    src = '{ex_rs1, ex_rs2};
    prd = '{mem_rd, wb_rd};
    pwr = '{mem_wr, wb_wr};
    for (int s = 0; s < 2; s++) begin
      pick[s] = 0;
      for (int p = 0; p < 2; p++)
        if (pick[s] == 0 && pwr[p] && src[s] != 5'd0 && prd[p] == src[s]) pick[s] = p + 1;
    end
    return {pick[0] == 1, pick[1] == 1, pick[0] == 2, pick[1] == 2};
  endfunction

  function automatic bit ref_load_use();
    return ex_read_mem && ex_write && ex_rd != 5'd0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [11:0] ref_vec(input bit th, input bit halted, input logic trap);
    logic frz, stl, fif, fid, fex, pcl, pct, hl;
    {frz, stl, fif, fid, fex, pcl, pct, hl} = '0;
    if (halted) begin
      stl = 1; fid = 1; hl = 1;
    end else if (trap) begin
      fif = 1; fid = 1; fex = 1; pct = !th;
    end else if (busy) begin
      frz = 1;
    end else if (branch) begin
      pcl = 1; fif = 1; fid = 1;
    end else if (ref_load_use()) begin
      stl = 1; fid = 1;
    end
    return {ref_fwd(), frz, stl, fif, fid, fex, pcl, pct, hl};
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_halt_h = 0; m_halt_r = 0;
      m_stall_h = 0; m_flush_h = 0; m_stall_r = 0; m_flush_r = 0;
    end else begin
      if (!m_halt_h) begin
        if (!trap_h && (busy || (!branch && ref_load_use()))) m_stall_h = sat_inc(m_stall_h, 65535);
        if (trap_h || (!busy && branch)) m_flush_h = sat_inc(m_flush_h, 65535);
        if (trap_h) m_halt_h = 1;
      end
      if (!m_halt_r) begin
        if (!trap_r && (busy || (!branch && ref_load_use()))) m_stall_r = sat_inc(m_stall_r, 7);
        if (trap_r || (!busy && branch)) m_flush_r = sat_inc(m_flush_r, 7);
      end
    end
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic set_idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_write, ex_read_mem, mem_wr, wb_wr} = '0;
    {branch, busy, trap_h, trap_r} = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); set_idle(); reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (obs_h !== 12'h000) begin bad++; $display("FAIL reset_outs_h got=%h want=000", obs_h); end
    total++; if (obs_r !== 12'h000) begin bad++; $display("FAIL reset_outs_r got=%h want=000", obs_r); end
    total++; if (scnt_h !== 16'd0 || fcnt_h !== 16'd0) begin bad++; $display("FAIL reset_cnt_h got=%0d/%0d want=0/0", scnt_h, fcnt_h); end
    @(negedge clk); reset_n = 1; #1;
    total++; if (obs_h !== 12'h000 || obs_r !== 12'h000) begin bad++; $display("FAIL idle_outs got=%h/%h want=000/000", obs_h, obs_r); end
  endtask

  task automatic test_forwarding();
    @(negedge clk); set_idle();
    ex_rs1 = 5; mem_rd = 5; mem_wr = 1; wb_rd = 5; wb_wr = 1; #1;
    total++; if ({fe1_h, fw1_h} !== 2'b10) begin bad++; $display("FAIL fwd_exmem_prio got=%b want=10", {fe1_h, fw1_h}); end
    @(negedge clk); ex_rs1 = 0; mem_rd = 0; wb_rd = 0; #1;
    total++; if ({fe1_h, fw1_h} !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b want=00", {fe1_h, fw1_h}); end
    @(negedge clk); ex_rs2 = 9; mem_rd = 9; mem_wr = 0; wb_rd = 9; wb_wr = 1; #1;
    total++; if ({fe2_h, fw2_h, fe1_h, fw1_h} !== 4'b0100) begin bad++; $display("FAIL fwd_memwb_rs2 got=%b want=0100", {fe2_h, fw2_h, fe1_h, fw1_h}); end
  endtask

  task automatic test_load_use();
    @(negedge clk); set_idle();
    ex_read_mem = 1; ex_write = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7; #1;
    total++; if ({stl_h, fid_h, fif_h} !== 3'b110) begin bad++; $display("FAIL load_use_stall got=%b want=110", {stl_h, fid_h, fif_h}); end
    total++; if (scnt_h !== 16'd0) begin bad++; $display("FAIL load_use_cnt_before got=%0d want=0", scnt_h); end
    @(negedge clk); set_idle(); mem_rd = 7; mem_wr = 1; ex_rs2 = 7; id_use_rs2 = 1; id_rs2 = 7; #1;
    total++; if ({stl_h, fid_h} !== 2'b00) begin bad++; $display("FAIL load_use_one_cycle got=%b want=00", {stl_h, fid_h}); end
    total++; if (scnt_h !== 16'd1 || scnt_r !== 3'd1) begin bad++; $display("FAIL load_use_cnt got=%0d/%0d want=1/1", scnt_h, scnt_r); end
  endtask

  task automatic test_branch_vs_load_use();
    @(negedge clk); set_idle();
    ex_read_mem = 1; ex_write = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3; branch = 1; #1;
    total++; if ({pcl_h, fif_h, fid_h, stl_h} !== 4'b1110) begin bad++; $display("FAIL branch_over_lu got=%b want=1110", {pcl_h, fif_h, fid_h, stl_h}); end
    @(negedge clk); set_idle(); #1;
    total++; if (fcnt_h !== 16'd1 || scnt_h !== 16'd1) begin bad++; $display("FAIL branch_cnt got=%0d/%0d want=1/1", fcnt_h, scnt_h); end
    total++; if ({pcl_h, fif_h} !== 2'b00) begin bad++; $display("FAIL branch_one_cycle got=%b want=00", {pcl_h, fif_h}); end
  endtask

  task automatic test_mem_wait_branch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_idle(); branch = 1; busy = 1; #1;
      total++;
      if ({frz_h, pcl_h, fif_h, fid_h, stl_h} !== 5'b10000) begin
        bad++; $display("FAIL mem_wait_freeze[%0d] got=%b want=10000", i, {frz_h, pcl_h, fif_h, fid_h, stl_h});
      end
    end
    @(negedge clk); busy = 0; #1;
    total++; if ({frz_h, pcl_h, fif_h, fid_h} !== 4'b0111) begin bad++; $display("FAIL mem_wait_release got=%b want=0111", {frz_h, pcl_h, fif_h, fid_h}); end
    total++; if (scnt_h !== 16'd4 || scnt_r !== 3'd4) begin bad++; $display("FAIL mem_wait_cnt got=%0d/%0d want=4/4", scnt_h, scnt_r); end
    @(negedge clk); set_idle(); #1;
    total++; if (fcnt_h !== 16'd2) begin bad++; $display("FAIL mem_wait_flush_cnt got=%0d want=2", fcnt_h); end
  endtask

  task automatic test_trap_halt();
    @(negedge clk); set_idle(); trap_h = 1; branch = 1; busy = 1; #1;
    total++; if ({fif_h, fid_h, fex_h, pct_h, frz_h, pcl_h, hlt_h} !== 7'b1110000) begin
      bad++; $display("FAIL trap_halt_flush got=%b want=1110000", {fif_h, fid_h, fex_h, pct_h, frz_h, pcl_h, hlt_h});
    end
    @(negedge clk); set_idle(); #1;
    total++; if ({hlt_h, stl_h, fid_h} !== 3'b111) begin bad++; $display("FAIL trap_halted got=%b want=111", {hlt_h, stl_h, fid_h}); end
    total++; if (fcnt_h !== 16'd3) begin bad++; $display("FAIL trap_flush_cnt got=%0d want=3", fcnt_h); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); branch = 1; busy = i[0]; trap_h = 1;
      ex_read_mem = 1; ex_write = 1; ex_rd = 2; id_use_rs1 = 1; id_rs1 = 2; #1;
      total++;
      if ({hlt_h, stl_h, fid_h, pcl_h, frz_h, fif_h, fex_h} !== 7'b1110000) begin
        bad++; $display("FAIL halt_hold[%0d] got=%b want=1110000", i, {hlt_h, stl_h, fid_h, pcl_h, frz_h, fif_h, fex_h});
      end
    end
    @(negedge clk); set_idle(); #1;
    total++; if (fcnt_h !== 16'd3 || scnt_h !== 16'd4) begin bad++; $display("FAIL halt_cnt_frozen got=%0d/%0d want=3/4", fcnt_h, scnt_h); end
    reset_n = 0;
    @(negedge clk); #1;
    total++; if (obs_h !== 12'h000 || scnt_h !== 16'd0 || fcnt_h !== 16'd0) begin
      bad++; $display("FAIL halt_reset got=%h/%0d/%0d want=000/0/0", obs_h, scnt_h, fcnt_h);
    end
    reset_n = 1;
  endtask

  task automatic test_trap_redirect();
    @(negedge clk); set_idle(); busy = 1; #1;
    total++; if (frz_r !== 1'b1) begin bad++; $display("FAIL redirect_busy got=%b want=1", frz_r); end
    @(negedge clk); busy = 1; trap_r = 1; branch = 1; #1;
    total++; if ({pct_r, fif_r, fid_r, fex_r, frz_r, pcl_r} !== 6'b111100) begin
      bad++; $display("FAIL redirect_trap got=%b want=111100", {pct_r, fif_r, fid_r, fex_r, frz_r, pcl_r});
    end
    @(negedge clk); set_idle(); branch = 1; #1;
    total++; if ({hlt_r, pcl_r, pct_r} !== 3'b010) begin bad++; $display("FAIL redirect_resume got=%b want=010", {hlt_r, pcl_r, pct_r}); end
    total++; if (fcnt_r !== 3'd1 || scnt_r !== 3'd1) begin bad++; $display("FAIL redirect_cnt got=%0d/%0d want=1/1", fcnt_r, scnt_r); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); set_idle(); busy = 1;
    end
    @(negedge clk); set_idle(); #1;
    total++; if (scnt_r !== 3'd7) begin bad++; $display("FAIL sat_stall_r got=%0d want=7", scnt_r); end
    total++; if (scnt_h !== 16'd14) begin bad++; $display("FAIL sat_stall_h got=%0d want=14", scnt_h); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      id_rs1 = 5'($urandom_range(3, 0)); id_rs2 = 5'($urandom_range(3, 0));
      ex_rs1 = 5'($urandom_range(3, 0)); ex_rs2 = 5'($urandom_range(3, 0));
      ex_rd  = 5'($urandom_range(3, 0)); mem_rd = 5'($urandom_range(3, 0));
      wb_rd  = 5'($urandom_range(3, 0));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_write = 1'($urandom); ex_read_mem = 1'($urandom);
      mem_wr = 1'($urandom); wb_wr = 1'($urandom);
      branch = ($urandom_range(3, 0) == 0);
      busy   = ($urandom_range(3, 0) == 0);
      trap_r = ($urandom_range(15, 0) == 0);
      trap_h = ($urandom_range(199, 0) == 0);
      #1;
      total++;
      if (obs_h !== ref_vec(1'b1, m_halt_h, trap_h)) begin
        bad++; $display("FAIL rand_h[%0d] got=%h want=%h", i, obs_h, ref_vec(1'b1, m_halt_h, trap_h));
      end
      total++;
      if (obs_r !== ref_vec(1'b0, m_halt_r, trap_r)) begin
        bad++; $display("FAIL rand_r[%0d] got=%h want=%h", i, obs_r, ref_vec(1'b0, m_halt_r, trap_r));
      end
      total++;
      if (int'(scnt_h) != m_stall_h || int'(fcnt_h) != m_flush_h ||
          int'(scnt_r) != m_stall_r || int'(fcnt_r) != m_flush_r) begin
        bad++;
        $display("FAIL rand_cnt[%0d] got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                 scnt_h, fcnt_h, scnt_r, fcnt_r, m_stall_h, m_flush_h, m_stall_r, m_flush_r);
      end
    end
  endtask

  initial begin
    set_idle();
    reset_n = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait_branch();
    test_trap_halt();
    test_trap_redirect();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
